// File: rtl/alu_pkg.sv
// Opcode map, legality check and FSM state type shared by the ALU, its decoder
// and the ALU share arbiter.
package alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD       = 6'h00;
    localparam logic [OP_W-1:0] OP_SLL       = 6'h01;
    localparam logic [OP_W-1:0] OP_SLT       = 6'h02;
    localparam logic [OP_W-1:0] OP_SLTU      = 6'h03;
    localparam logic [OP_W-1:0] OP_XOR       = 6'h04;
    localparam logic [OP_W-1:0] OP_SRL       = 6'h05;
    localparam logic [OP_W-1:0] OP_OR        = 6'h06;
    localparam logic [OP_W-1:0] OP_AND       = 6'h07;
    localparam logic [OP_W-1:0] OP_SUB       = 6'h08;
    localparam logic [OP_W-1:0] OP_SRA       = 6'h09;
    localparam logic [OP_W-1:0] OP_SRLI_SRAI = 6'h38;
    localparam logic [OP_W-1:0] OP_XORI      = 6'h3A;
    localparam logic [OP_W-1:0] OP_ORI       = 6'h3B;
    localparam logic [OP_W-1:0] OP_ANDI      = 6'h3C;
    localparam logic [OP_W-1:0] OP_SLLI      = 6'h3D;
    localparam logic [OP_W-1:0] OP_SLTI      = 6'h3E;
    localparam logic [OP_W-1:0] OP_ADDI      = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // 0x39 sits inside the immediate block but has no ALU operation behind it.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_SRA) || (op == OP_SRLI_SRAI) || (op >= OP_XORI);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational: a lone requester always wins,
// a tie goes to the requester that did not win last time.
module rr_arbiter2 (
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_idx_o
);

    assign grant_o[0]  = req_valid_i[0] & (~req_valid_i[1] | last_grant_i);
    assign grant_o[1]  = req_valid_i[1] & (~req_valid_i[0] | ~last_grant_i);
    assign grant_idx_o = grant_o[1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle ALU between two requesters: accept -> EXEC -> RESP,
// minimum three cycles per operation; the response is held until its owner takes it.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6,
    parameter int IMM_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_rs1,
    input  logic [DATA_W-1:0] req0_rs2,
    input  logic [CTRL_W-1:0] req0_alu_control,
    input  logic [IMM_W-1:0]  req0_imm_val,
    input  logic [DATA_W-1:0] req1_rs1,
    input  logic [DATA_W-1:0] req1_rs2,
    input  logic [CTRL_W-1:0] req1_alu_control,
    input  logic [IMM_W-1:0]  req1_imm_val,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic [CTRL_W-1:0] alu_control,
    output logic [IMM_W-1:0]  alu_imm_val,
    input  logic [DATA_W-1:0] alu_result
);

    state_e            state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] alu_rs1_q;
    logic [DATA_W-1:0] alu_rs2_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [IMM_W-1:0]  alu_imm_q;

    logic [1:0]        grant;
    logic              grant_idx;
    logic              accept;
    logic              legal;
    logic [DATA_W-1:0] rs1_d;
    logic [DATA_W-1:0] rs2_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic [IMM_W-1:0]  imm_d;

    rr_arbiter2 u_rr (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    // Ready is gated by rst so no handshake can complete on a cycle being reset.
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : 2'b00;
    assign accept    = |req_ready;

    assign rs1_d  = grant_idx ? req1_rs1         : req0_rs1;
    assign rs2_d  = grant_idx ? req1_rs2         : req0_rs2;
    assign ctrl_d = grant_idx ? req1_alu_control : req0_alu_control;
    assign imm_d  = grant_idx ? req1_imm_val     : req0_imm_val;

    // Any control bits above the defined opcode width make the operation illegal.
    assign legal = op_legal(alu_ctrl_q[OP_W-1:0]) && ((alu_ctrl_q >> OP_W) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            alu_rs1_q    <= '0;
            alu_rs2_q    <= '0;
            alu_ctrl_q   <= '0;
            alu_imm_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        alu_rs1_q    <= rs1_d;
                        alu_rs2_q    <= rs2_d;
                        alu_ctrl_q   <= ctrl_d;
                        alu_imm_q    <= imm_d;
                        owner_q      <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q <= legal ? alu_result : '0;
                    rsp_err_q    <= ~legal;
                    rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_err     = rsp_err_q;
    assign alu_rs1     = alu_rs1_q;
    assign alu_rs2     = alu_rs2_q;
    assign alu_control = alu_ctrl_q;
    assign alu_imm_val = alu_imm_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the datapath side.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [5:0]  req0_alu_control, req1_alu_control;
    logic [11:0] req0_imm_val, req1_imm_val;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [31:0] alu_rs1, alu_rs2, alu_result;
    logic [5:0]  alu_control;
    logic [11:0] alu_imm_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(6), .IMM_W(12)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req0_rs1         (req0_rs1),
        .req0_rs2         (req0_rs2),
        .req0_alu_control (req0_alu_control),
        .req0_imm_val     (req0_imm_val),
        .req1_rs1         (req1_rs1),
        .req1_rs2         (req1_rs2),
        .req1_alu_control (req1_alu_control),
        .req1_imm_val     (req1_imm_val),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_result       (rsp_result),
        .rsp_err          (rsp_err),
        .alu_rs1          (alu_rs1),
        .alu_rs2          (alu_rs2),
        .alu_control      (alu_control),
        .alu_imm_val      (alu_imm_val),
        .alu_result       (alu_result)
    );

    // Behavioural ALU; undefined opcodes return a recognisable nonzero pattern.
    logic [31:0] simm;
    assign simm = {{20{alu_imm_val[11]}}, alu_imm_val};
    always_comb begin
        alu_result = 32'hBAD0_0000 ^ alu_rs1;
        case (alu_control)
            6'h00: alu_result = alu_rs1 + alu_rs2;
            6'h08: alu_result = alu_rs1 - alu_rs2;
            6'h09: alu_result = $unsigned($signed(alu_rs1) >>> alu_rs2[4:0]);
            6'h38: alu_result = alu_rs1 >> alu_imm_val[4:0];
            6'h3A: alu_result = alu_rs1 ^ simm;
            6'h3F: alu_result = alu_rs1 + simm;
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  ctrl;
        logic [11:0] imm;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int r, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [5:0] ctrl, input logic [11:0] imm);
        if (r == 0) begin
            req0_rs1 = rs1; req0_rs2 = rs2; req0_alu_control = ctrl; req0_imm_val = imm;
        end else begin
            req1_rs1 = rs1; req1_rs2 = rs2; req1_alu_control = ctrl; req1_imm_val = imm;
        end
    endtask

    // One uncontended operation; request fields are scrambled right after accept.
    task automatic do_op(input int r, input vec_t v);
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        set_fields(r, v.rs1, v.rs2, v.ctrl, v.imm);
        req_valid = oh;
        #1;
        chk("accept_ready", {30'd0, req_ready}, {30'd0, oh});
        tick;
        req_valid = 2'b00;
        set_fields(r, 32'd99, 32'd1, 6'h00, 12'd0);
        #1;
        chk("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("exec_alu_rs1", alu_rs1, v.rs1);
        chk("exec_alu_ctrl", {26'd0, alu_control}, {26'd0, v.ctrl});
        tick;
        chk("resp_valid", {30'd0, rsp_valid}, {30'd0, oh});
        chk("resp_result", rsp_result, v.exp_res);
        chk("resp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        rsp_ready = oh;
        tick;
        rsp_ready = 2'b00;
        chk("idle_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("idle_alu_imm_held", {20'd0, alu_imm_val}, {20'd0, v.imm});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'd5,          32'd3, 6'h00, 12'h000, 32'd8,          1'b0};
        vecs[1]  = '{32'd10,         32'd4, 6'h08, 12'h000, 32'd6,          1'b0};
        vecs[2]  = '{32'd10,         32'd4, 6'h39, 12'h000, 32'd0,          1'b1};
        vecs[3]  = '{32'd10,         32'd4, 6'h08, 12'h000, 32'd6,          1'b0};
        vecs[4]  = '{32'd7,          32'd0, 6'h3F, 12'h001, 32'd8,          1'b0};
        vecs[5]  = '{32'd10,         32'd0, 6'h3F, 12'hFFF, 32'd9,          1'b0};
        vecs[6]  = '{32'd3,          32'd0, 6'h0A, 12'h000, 32'd0,          1'b1};
        vecs[7]  = '{32'h80,         32'd0, 6'h38, 12'h003, 32'h10,         1'b0};
        vecs[8]  = '{32'h8000_0000,  32'd4, 6'h09, 12'h000, 32'hF800_0000,  1'b0};
        vecs[9]  = '{32'hF0,         32'd0, 6'h3A, 12'h0FF, 32'h0F,         1'b0};
        vecs[10] = '{32'd5,          32'd0, 6'h37, 12'h000, 32'd0,          1'b1};
        vecs[11] = '{32'hFFFF_FFFF,  32'd1, 6'h00, 12'h000, 32'd0,          1'b0};

        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        set_fields(0, 32'd0, 32'd0, 6'h00, 12'd0);
        set_fields(1, 32'd0, 32'd0, 6'h00, 12'd0);
        tick;
        tick;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_alu_rs1", alu_rs1, 32'd0);
        chk("rst_alu_ctrl", {26'd0, alu_control}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) do_op(i % 2, vecs[i]);

        // Backpressure on requester 1 while requester 0 waits.
        set_fields(1, 32'd20, 32'd22, 6'h00, 12'd0);
        req_valid = 2'b10;
        #1;
        chk("bp_accept", {30'd0, req_ready}, 32'd2);
        tick;
        set_fields(0, 32'd1, 32'd2, 6'h00, 12'd0);
        req_valid = 2'b01;
        tick;
        for (int c = 0; c < 5; c++) begin
            rsp_ready = (c == 2) ? 2'b01 : 2'b00;
            #1;
            chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
            chk("bp_rsp_result", rsp_result, 32'd42);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
            tick;
        end
        rsp_ready = 2'b10;
        #1;
        chk("bp_pulse_valid", {30'd0, rsp_valid}, 32'd2);
        tick;
        rsp_ready = 2'b00;
        #1;
        chk("bp_waiter_accept", {30'd0, req_ready}, 32'd1);
        tick;
        req_valid = 2'b00;
        tick;
        chk("bp_waiter_valid", {30'd0, rsp_valid}, 32'd1);
        chk("bp_waiter_result", rsp_result, 32'd3);
        rsp_ready = 2'b01;
        tick;
        rsp_ready = 2'b00;

        // Reset while the operation is in EXEC.
        set_fields(0, 32'd1, 32'd1, 6'h00, 12'd0);
        req_valid = 2'b01;
        #1;
        chk("rx_accept", {30'd0, req_ready}, 32'd1);
        tick;
        req_valid = 2'b00;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        rsp_ready = 2'b11;
        chk("rx_rsp_result", rsp_result, 32'd0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rx_no_rsp", {30'd0, rsp_valid}, 32'd0);
            tick;
        end

        // Continuous tie: grants alternate starting with requester 0.
        set_fields(0, 32'd1, 32'd2, 6'h00, 12'd0);
        set_fields(1, 32'd100, 32'd200, 6'h00, 12'd0);
        req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            logic [1:0] exp_g;
            exp_g = (((c / 3) % 2) == 0) ? 2'b01 : 2'b10;
            #1;
            chk("tie_req_ready", {30'd0, req_ready}, (c % 3 == 0) ? {30'd0, exp_g} : 32'd0);
            chk("tie_rsp_valid", {30'd0, rsp_valid}, (c % 3 == 2) ? {30'd0, exp_g} : 32'd0);
            if (c % 3 == 2)
                chk("tie_result", rsp_result, (exp_g == 2'b01) ? 32'd3 : 32'd300);
            tick;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        chk("tie_done_idle", {30'd0, rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
